// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains bytes from a show-ahead FIFO read port and sends each one
// as an asynchronous UART frame: start bit, data LSB first, optional parity, stop bit(s).
// Runs entirely in the FIFO read-clock domain. A new pop can happen in the last stop
// cycle, so back-to-back frames have no idle gap.
module fifo_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + STOP_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state, state_d;
    logic [BAUD_W-1:0]     baud_cnt, baud_d;
    logic [BIT_W-1:0]      bit_cnt, bit_d;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic                  par_bit, par_d;
    logic                  tx_d;
    logic                  baud_wrap;
    logic                  last_stop;
    logic                  pop;

    // Parity over the whole byte, inverted when odd parity is selected.
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    // Next-state logic, pop strobe and the value tx takes on the next cycle.
    always_comb begin
        state_d    = state;
        baud_d     = baud_cnt;
        bit_d      = bit_cnt;
        shreg_d    = shreg;
        par_d      = par_bit;
        tx_d       = 1'b1;
        baud_wrap  = (baud_cnt == BAUD_LAST);
        last_stop  = (state == STOP) && baud_wrap && (bit_cnt == STOP_LAST);
        // Reset blocks the pop so an aborted cycle never consumes a FIFO entry.
        pop        = !rst && tx_en && !rempty && ((state == IDLE) || last_stop);

        if (state != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shreg_d = shreg >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop overrides the idle/stop exit and loads the next byte directly.
        if (pop) begin
            state_d = START;
            baud_d  = '0;
            bit_d   = '0;
            shreg_d = rdata;
            par_d   = parity_of(rdata);
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase

        rinc       = pop;
        frame_done = last_stop && !rst;
        busy       = (state != IDLE);
    end

    // State, counters, shift register and the registered serial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            par_bit  <= par_d;
            tx       <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances at CLK_DIV=4 (no parity, even, odd)
// share one set of inputs; directed vectors with hand-computed frames.
module tb_fifo_uart_tx;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic       rempty;
    logic [7:0] rdata;

    logic rinc, tx, busy, frame_done;
    logic rinc_e, tx_e, busy_e, fd_e;
    logic rinc_o, tx_o, busy_o, fd_o;

    int checks   = 0;
    int failures = 0;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .tx_en(tx_en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc_e), .tx(tx_e), .busy(busy_e), .frame_done(fd_e)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .tx_en(tx_en), .rempty(rempty), .rdata(rdata),
        .rinc(rinc_o), .tx(tx_o), .busy(busy_o), .frame_done(fd_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // bit i = serial bit i of the frame (start first)
    } frame_vec_t;

    frame_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic r, input logic en, input logic emp, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst    = r;
        tx_en  = en;
        rempty = emp;
        rdata  = d;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [19:0] exp2;
        logic [9:0]  exp_c3;
        int pops, fds, pop1, pop2, fd_last, gaps, tx_errs, busy_cnt, txlow_cnt;

        rst    = 1'b1;
        tx_en  = 1'b1;
        rempty = 1'b0;
        rdata  = 8'h5A;

        vecs[0] = '{data: 8'hA5, bits: 10'b1101001010};
        vecs[1] = '{data: 8'h00, bits: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, bits: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, bits: 10'b1001111000};
        vecs[4] = '{data: 8'h01, bits: 10'b1000000010};

        // Reset holds everything idle even with data available.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h5A);
            check("reset_tx", tx, 1);
            check("reset_rinc", rinc, 0);
            check("reset_busy", busy, 0);
            check("reset_fd", frame_done, 0);
        end

        // Single frames from the vector table.
        foreach (vecs[v]) begin
            drive(1'b0, 1'b1, 1'b0, vecs[v].data);
            check("tbl_pop_rinc", rinc, 1);
            check("tbl_pop_tx_idle", tx, 1);
            for (int i = 0; i < 40; i++) begin
                drive(1'b0, 1'b1, 1'b1, 8'h00);
                check("tbl_tx", tx, vecs[v].bits[i/4]);
                check("tbl_busy", busy, 1);
                check("tbl_rinc", rinc, 0);
                check("tbl_frame_done", frame_done, (i == 39));
            end
            for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 8'h00);
            check("tbl_after_busy", busy, 0);
            check("tbl_after_tx", tx, 1);
        end

        // Parity: 0xA5 has four ones -> even bit 0, odd bit 1; frame is 44 cycles.
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'hA5);
        check("par_even_rinc", rinc_e, 1);
        check("par_odd_rinc", rinc_o, 1);
        for (int i = 0; i < 44; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h00);
            if (i >= 36 && i <= 39) begin
                check("par_even_bit", tx_e, 0);
                check("par_odd_bit", tx_o, 1);
            end
            if (i == 39 || i == 43) begin
                check("par_even_fd", fd_e, (i == 43));
                check("par_odd_fd", fd_o, (i == 43));
                check("par_even_busy", busy_e, 1);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("par_even_idle", busy_e, 0);
        check("par_odd_idle", busy_o, 0);

        // Back-to-back: FIFO holds 0x00 then 0xFF.
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        q = {8'h00, 8'hFF};
        exp2 = {10'b1111111110, 10'b1000000000};
        pops = 0; fds = 0; pop1 = -1; pop2 = -1; fd_last = -1; gaps = 0; tx_errs = 0;
        for (int c = 0; c < 82; c++) begin
            drive(1'b0, 1'b1, (q.size() == 0), (q.size() != 0) ? q[0] : 8'h00);
            if (rinc) begin
                pops++;
                if (pops == 1) pop1 = c;
                else pop2 = c;
                if (q.size() != 0) void'(q.pop_front());
            end
            if (frame_done) begin
                fds++;
                fd_last = c;
            end
            if (c >= 1 && c <= 80) begin
                if (busy !== 1'b1) gaps++;
                if (tx !== exp2[(c-1)/4]) tx_errs++;
            end
            if (c == 81) check("b2b_end_busy", busy, 0);
        end
        check("b2b_pops", pops, 2);
        check("b2b_frames", fds, 2);
        check("b2b_pop1_cycle", pop1, 0);
        check("b2b_pop2_cycle", pop2, 40);
        check("b2b_last_fd_cycle", fd_last, 80);
        check("b2b_busy_gaps", gaps, 0);
        check("b2b_tx_errors", tx_errs, 0);

        // Empty FIFO for 100 cycles.
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        pops = 0; busy_cnt = 0; txlow_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h77);
            if (rinc) pops++;
            if (busy) busy_cnt++;
            if (!tx) txlow_cnt++;
        end
        check("empty_rinc", pops, 0);
        check("empty_busy", busy_cnt, 0);
        check("empty_tx_low", txlow_cnt, 0);

        // tx_en low with data available.
        pops = 0; busy_cnt = 0; txlow_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h77);
            if (rinc) pops++;
            if (busy) busy_cnt++;
            if (!tx) txlow_cnt++;
        end
        check("gated_rinc", pops, 0);
        check("gated_busy", busy_cnt, 0);
        check("gated_tx_low", txlow_cnt, 0);

        // tx_en dropped mid-frame: frame completes, no further pop.
        pops = 0; fds = 0; fd_last = -1;
        for (int c = 0; c < 60; c++) begin
            drive(1'b0, (c < 10), 1'b0, 8'h5A);
            if (c == 0) check("drop_first_rinc", rinc, 1);
            if (rinc) pops++;
            if (frame_done) begin
                fds++;
                fd_last = c;
            end
        end
        check("drop_pops", pops, 1);
        check("drop_frames", fds, 1);
        check("drop_fd_cycle", fd_last, 40);
        check("drop_end_busy", busy, 0);
        check("drop_end_tx", tx, 1);

        // Reset during DATA bit 3 of 0x33, then a fresh frame of 0xC3.
        drive(1'b1, 1'b1, 1'b1, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h33);
        check("rmid_pop", rinc, 1);
        for (int c = 1; c < 18; c++) drive(1'b0, 1'b1, 1'b1, 8'h00);
        check("rmid_bit3_tx", tx, 0);
        check("rmid_bit3_busy", busy, 1);
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        check("rmid_rst_rinc", rinc, 0);
        check("rmid_rst_fd", frame_done, 0);
        drive(1'b0, 1'b1, 1'b0, 8'hC3);
        check("rmid_after_tx", tx, 1);
        check("rmid_after_busy", busy, 0);
        check("rmid_new_pop", rinc, 1);
        exp_c3 = 10'b1110000110;
        tx_errs = 0; pops = 0; fds = 0;
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'h33);
            if (i < 40 && tx !== exp_c3[i/4]) tx_errs++;
            if (rinc) pops++;
            if (frame_done) fds++;
        end
        check("rmid_new_frame_tx", tx_errs, 0);
        check("rmid_no_extra_pop", pops, 0);
        check("rmid_one_frame", fds, 1);
        check("rmid_final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
